// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator
//   Backplane bus master. It runs one memory or IO read/write cycle for each
//   command accepted from the console/DMA command port. It drives request,
//   address flags and write data, then waits for busACKI. On a read it
//   captures the read data. If no acknowledge arrives within TIMEOUT request
//   cycles, it reports a non-existent-memory (NXM) error.
//
//   Bits are numbered PDP-10 style: bit 0 is the MSB of each word.
//
//   Parameters
//     TIMEOUT  request cycles without busACKI before NXM (2..255)
//     IODEV    device field placed in address bits [14:17] on IO cycles
//
//   Ports
//     clkR, rst                  clock; asynchronous active-high reset
//     cmdGO/WR/IO/PHYS           command strobe and cycle type
//     cmdADDR[14:35]             memory address, or IO address (low 18 bits)
//     cmdDATA[0:35]              write data
//     cmdBUSY, cmdDONE, cmdNXM   status: busy, completion pulse, NXM error
//     cmdRDDATA[0:35]            last captured read data
//     busREQO, busACKI           bus request / acknowledge
//     busADDRO[0:35]             flags (3 READ, 5 WRITE, 8 PHYS, 10 IO) + address
//     busDATAO, busDATAI         write data out / read data in
//
//   Optional build macro
//     KS10_MEMINIT_RETRY_EN  retries once after a timeout, dropping busREQO
//                            for one cycle, before it reports NXM.

module mem_bus_initiator #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [0:3]  IODEV   = 4'd0
) (
  input  logic         clkR,
  input  logic         rst,
  input  logic         cmdGO,
  input  logic         cmdWR,
  input  logic         cmdIO,
  input  logic         cmdPHYS,
  input  logic [14:35] cmdADDR,
  input  logic [0:35]  cmdDATA,
  output logic         cmdBUSY,
  output logic         cmdDONE,
  output logic         cmdNXM,
  output logic [0:35]  cmdRDDATA,
  output logic         busREQO,
  input  logic         busACKI,
  output logic [0:35]  busADDRO,
  output logic [0:35]  busDATAO,
  input  logic [0:35]  busDATAI
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
`ifdef KS10_MEMINIT_RETRY_EN
    , GAP
`endif
  } state_t;

  state_t      state;
  logic [7:0]  count;
  logic [0:35] lat_addr;
  logic [0:35] lat_data;
  logic        lat_rd;
  logic        last_try;

`ifdef KS10_MEMINIT_RETRY_EN
  logic        retry;

  always_comb begin
    last_try = retry;
  end
`else
  always_comb begin
    last_try = 1'b1;
  end
`endif

  // Build the address word: flags plus either the memory address or the
  // device/IO-register pair.
  function automatic logic [0:35] addr_word(input logic wr, input logic io,
                                            input logic phys,
                                            input logic [14:35] addr);
    logic [0:35] w;
    w     = '0;
    w[3]  = ~wr;
    w[5]  = wr;
    w[8]  = io | phys;
    w[10] = io;
    if (io) begin
      w[14:17] = IODEV;
      w[18:35] = addr[18:35];
    end else begin
      w[14:35] = addr;
    end
    return w;
  endfunction

  always_ff @(posedge clkR or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_rd    <= 1'b0;
      cmdBUSY   <= 1'b0;
      cmdDONE   <= 1'b0;
      cmdNXM    <= 1'b0;
      cmdRDDATA <= '0;
      busREQO   <= 1'b0;
      busADDRO  <= '0;
      busDATAO  <= '0;
`ifdef KS10_MEMINIT_RETRY_EN
      retry     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmdGO) begin
            // Latch the whole command so the inputs may change afterwards.
            lat_addr <= addr_word(cmdWR, cmdIO, cmdPHYS, cmdADDR);
            lat_data <= cmdWR ? cmdDATA : '0;
            lat_rd   <= ~cmdWR;
            busADDRO <= addr_word(cmdWR, cmdIO, cmdPHYS, cmdADDR);
            busDATAO <= cmdWR ? cmdDATA : '0;
            busREQO  <= 1'b1;
            cmdBUSY  <= 1'b1;
            cmdNXM   <= 1'b0;
            count    <= '0;
`ifdef KS10_MEMINIT_RETRY_EN
            retry    <= 1'b0;
`endif
            state    <= REQ;
          end
        end

        REQ: begin
          // If ACK arrives in the timeout cycle, the ACK takes priority.
          if (busACKI || (count == LAST && last_try)) begin
            if (busACKI && lat_rd) begin
              cmdRDDATA <= busDATAI;
            end
            cmdNXM   <= ~busACKI;
            cmdDONE  <= 1'b1;
            busREQO  <= 1'b0;
            busADDRO <= '0;
            busDATAO <= '0;
            state    <= DONE;
`ifdef KS10_MEMINIT_RETRY_EN
          end else if (count == LAST) begin
            retry    <= 1'b1;
            count    <= '0;
            busREQO  <= 1'b0;
            busADDRO <= '0;
            busDATAO <= '0;
            state    <= GAP;
`endif
          end else begin
            count <= count + 8'd1;
          end
        end

`ifdef KS10_MEMINIT_RETRY_EN
        GAP: begin
          busREQO  <= 1'b1;
          busADDRO <= lat_addr;
          busDATAO <= lat_data;
          state    <= REQ;
        end
`endif

        DONE: begin
          cmdDONE <= 1'b0;
          cmdBUSY <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb_mem_bus_initiator
//   Self-checking bench for mem_bus_initiator. Directed vectors come from a
//   table. Random commands are checked against a cycle-count/outcome model.
//   Two hand-written sequences cover a cmdGO while busy and a reset in the
//   middle of a cycle.

module tb_mem_bus_initiator;

  localparam int unsigned TIMEOUT = 64;
  localparam logic [0:3]  IODEV   = 4'd5;

  logic         clkR = 1'b0;
  logic         rst;
  logic         cmdGO, cmdWR, cmdIO, cmdPHYS;
  logic [14:35] cmdADDR;
  logic [0:35]  cmdDATA;
  logic         cmdBUSY, cmdDONE, cmdNXM;
  logic [0:35]  cmdRDDATA;
  logic         busREQO, busACKI;
  logic [0:35]  busADDRO, busDATAO, busDATAI;

  mem_bus_initiator #(.TIMEOUT(TIMEOUT), .IODEV(IODEV)) dut (
    .clkR(clkR), .rst(rst),
    .cmdGO(cmdGO), .cmdWR(cmdWR), .cmdIO(cmdIO), .cmdPHYS(cmdPHYS),
    .cmdADDR(cmdADDR), .cmdDATA(cmdDATA),
    .cmdBUSY(cmdBUSY), .cmdDONE(cmdDONE), .cmdNXM(cmdNXM),
    .cmdRDDATA(cmdRDDATA),
    .busREQO(busREQO), .busACKI(busACKI),
    .busADDRO(busADDRO), .busDATAO(busDATAO), .busDATAI(busDATAI)
  );

  always #5 clkR = ~clkR;

  int tests = 0;
  int fails = 0;
  logic [0:35] rd_model = '0;

  typedef struct {
    logic         wr;
    logic         io;
    logic         phys;
    logic [14:35] addr;
    logic [0:35]  data;
    logic [0:35]  rdata;
    int           ack_at;    // REQ cycle (1-based) that the responder acks on; 0 = never
    logic [0:35]  exp_addr;
  } vec_t;

  vec_t tbl [7];

  function automatic void check(input string name, input logic [35:0] act,
                                input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %o expected %o", name, act, exp);
    end
  endfunction

  // Address word from weights: bit k (MSB = bit 0) has weight 2**(35-k).
  function automatic logic [35:0] exp_word(input logic wr, input logic io,
                                           input logic phys,
                                           input logic [21:0] addr);
    logic [35:0] w;
    w = wr ? (36'd1 << 30) : (36'd1 << 32);
    if (io || phys) w = w + (36'd1 << 27);
    if (io) w = w + (36'd1 << 25) + (36'(IODEV) << 18) + 36'(addr % 22'd262144);
    else    w = w + 36'(addr);
    return w;
  endfunction

  // Outcome model: how many REQ-high cycles, whether an ACK lands, and the
  // number of dropped-request cycles between attempts.
  function automatic void model(input int ack_at, output bit acked,
                                output int req, output int gap);
    int limit;
`ifdef KS10_MEMINIT_RETRY_EN
    limit = 2 * TIMEOUT;
`else
    limit = TIMEOUT;
`endif
    acked = (ack_at >= 1 && ack_at <= limit);
    req   = acked ? ack_at : limit;
    gap   = (req > int'(TIMEOUT)) ? 1 : 0;
  endfunction

  function automatic logic [0:35] rnd36();
    return {4'($urandom), 32'($urandom)};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_cmd(input vec_t v, input bit poke);
    logic [0:35] exp_wdata;
    bit acked;
    int exp_req, exp_gap;
    int req_n = 0;
    int gap_n = 0;
    int cyc = 0;
    exp_wdata = v.wr ? v.data : '0;
    model(v.ack_at, acked, exp_req, exp_gap);
    cmdGO = 1'b1; cmdWR = v.wr; cmdIO = v.io; cmdPHYS = v.phys;
    cmdADDR = v.addr; cmdDATA = v.data;
    @(negedge clkR);
    cmdGO = 1'b0; cmdWR = 1'($urandom); cmdIO = 1'($urandom);
    cmdPHYS = 1'($urandom); cmdADDR = 22'($urandom); cmdDATA = rnd36();
    while (!cmdDONE && cyc < 400) begin
      busDATAI = rnd36();
      if (busREQO) begin
        req_n++;
        check("req_addr", busADDRO, v.exp_addr);
        check("req_wdata", busDATAO, exp_wdata);
        if (req_n == 1) begin
          check("nxm_cleared", 36'(cmdNXM), 36'd0);
          check("busy_in_req", 36'(cmdBUSY), 36'd1);
        end
        busACKI = (req_n == v.ack_at);
        if (busACKI) busDATAI = v.rdata;
      end else begin
        gap_n++;
        check("gap_addr", busADDRO, 36'd0);
        busACKI = 1'($urandom);
      end
      cmdGO = poke && (req_n == 2);
      @(negedge clkR);
      cyc++;
    end
    if (!cmdDONE) check("done_seen", 36'd0, 36'd1);
    busACKI = 1'($urandom);
    cmdGO   = poke;
    if (acked && !v.wr) rd_model = v.rdata;
    check("req_cycles", 36'(req_n), 36'(exp_req));
    check("gap_cycles", 36'(gap_n), 36'(exp_gap));
    check("done_latency", 36'(cyc), 36'(exp_req + exp_gap));
    check("done_nxm", 36'(cmdNXM), 36'(!acked));
    check("done_rddata", cmdRDDATA, rd_model);
    check("done_busy", 36'(cmdBUSY), 36'd1);
    check("done_req", 36'(busREQO), 36'd0);
    check("done_addr", busADDRO, 36'd0);
    @(negedge clkR);
    cmdGO = 1'b0; busACKI = 1'b0;
    check("post_done", 36'(cmdDONE), 36'd0);
    check("post_busy", 36'(cmdBUSY), 36'd0);
    check("post_req", 36'(busREQO), 36'd0);
    check("post_nxm", 36'(cmdNXM), 36'(!acked));
  endtask

  initial begin
    vec_t v;
    int r;
    //        wr    io    phys  addr                  data             rdata            ack  exp_addr
    tbl[0] = '{1'b0, 1'b0, 1'b1, 22'o123456,          36'o0,           36'o123456765432, 2,   36'o041000123456};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 22'o001000,          36'o777000111222,36'o0,            1,   36'o010000001000};
    tbl[2] = '{1'b0, 1'b1, 1'b0, {4'hF, 18'o100000},  36'o0,           36'o000000777777, 3,   36'o041205100000};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 22'o0777777,         36'o0,           36'o111111111111, 0,   36'o041000777777};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 22'o000123,          36'o525252525252,36'o0,            64,  36'o011205000123};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 22'o17000000,        36'o0,           36'o700000000007, 100, 36'o040017000000};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 22'o0,               36'o0,           36'o000000000001, 1,   36'o040000000000};

    rst = 1'b1; cmdGO = 1'b0; cmdWR = 1'b0; cmdIO = 1'b0; cmdPHYS = 1'b0;
    cmdADDR = '0; cmdDATA = '0; busACKI = 1'b0; busDATAI = '0;
    repeat (2) @(negedge clkR);
    check("rst_req", 36'(busREQO), 36'd0);
    check("rst_busy", 36'(cmdBUSY), 36'd0);
    check("rst_done", 36'(cmdDONE), 36'd0);
    check("rst_nxm", 36'(cmdNXM), 36'd0);
    check("rst_rddata", cmdRDDATA, 36'd0);
    check("rst_addr", busADDRO, 36'd0);
    check("rst_wdata", busDATAO, 36'd0);
    rst = 1'b0;
    @(negedge clkR);

    for (int i = 0; i < 7; i++) run_cmd(tbl[i], 1'b0);

    // cmdGO pulsed during REQ and in the DONE cycle: only one cycle runs.
    v = '{1'b0, 1'b0, 1'b1, 22'o000777, 36'o0, 36'o246135024613, 3, 36'd0};
    v.exp_addr = exp_word(v.wr, v.io, v.phys, v.addr);
    run_cmd(v, 1'b1);
    @(negedge clkR);
    check("poke_no_restart", 36'(busREQO), 36'd0);

    // Randomized commands.
    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom);
      v.io    = 1'($urandom);
      v.phys  = 1'($urandom);
      v.addr  = 22'($urandom);
      v.data  = rnd36();
      v.rdata = rnd36();
      r = int'($urandom_range(0, 9));
      if (r == 0)      v.ack_at = 0;
      else if (r == 1) v.ack_at = int'($urandom_range(TIMEOUT - 2, 2 * TIMEOUT + 2));
      else             v.ack_at = int'($urandom_range(1, 6));
      v.exp_addr = exp_word(v.wr, v.io, v.phys, v.addr);
      run_cmd(v, 1'b0);
    end

    // Reset in the middle of a request.
    v = '{1'b0, 1'b0, 1'b1, 22'o000042, 36'o0, 36'o5, 0, 36'd0};
    cmdGO = 1'b1; cmdWR = v.wr; cmdIO = v.io; cmdPHYS = v.phys; cmdADDR = v.addr;
    @(negedge clkR);
    cmdGO = 1'b0;
    repeat (4) @(negedge clkR);
    check("pre_rst_req", 36'(busREQO), 36'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_req", 36'(busREQO), 36'd0);
    check("mid_rst_busy", 36'(cmdBUSY), 36'd0);
    check("mid_rst_addr", busADDRO, 36'd0);
    check("mid_rst_rddata", cmdRDDATA, 36'd0);
    rd_model = '0;
    @(negedge clkR);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clkR);
      check("after_rst_done", 36'(cmdDONE), 36'd0);
      check("after_rst_req", 36'(busREQO), 36'd0);
    end
    v = '{1'b0, 1'b0, 1'b0, 22'o3000001, 36'o0, 36'o707070707070, 2, 36'd0};
    v.exp_addr = exp_word(v.wr, v.io, v.phys, v.addr);
    run_cmd(v, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Backplane bus master that issues single memory or IO read/write cycles on behalf of a simple command port (console/DMA front end).
- It is the initiator counterpart of the memory responder: it drives request, address flags and write data, then waits for acknowledge.
- It captures read data on acknowledge, or flags a non-existent-memory (NXM) error on timeout.
- It sits between the console command logic and the backplane bus arbiter/mux.

Parameters:
- TIMEOUT, 64, number of clkR cycles in REQ without busACKI before NXM is declared (range 2..255).
- IODEV, 4'd0, device field [0:3] placed in the IO address for IO cycles.

Ports:
- clkR  input  1  bus clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmdGO  input  1  start a cycle; sampled only in IDLE.
- cmdWR  input  1  1 = write cycle, 0 = read cycle.
- cmdIO  input  1  1 = IO cycle (physical), 0 = memory cycle.
- cmdPHYS  input  1  physical-address flag for memory cycles.
- cmdADDR  input  22  [14:35] memory address or IO address (low 18 bits used for IO).
- cmdDATA  input  36  [0:35] write data.
- cmdBUSY  output  1  high from the cycle after accepted cmdGO until the DONE cycle, inclusive.
- cmdDONE  output  1  one-cycle pulse at completion (ack or timeout).
- cmdNXM  output  1  set with cmdDONE on timeout; held until the next accepted cmdGO.
- cmdRDDATA  output  36  [0:35] captured read data; held until the next read completes.
- busREQO  output  1  bus request.
- busACKI  input  1  bus acknowledge from the responder.
- busADDRO  output  36  [0:35] flags plus address.
- busDATAO  output  36  [0:35] write data.
- busDATAI  input  36  [0:35] read data from the responder.

Behaviour:
- Address word layout:
  - bit 3 READ, bit 4 WRTEST (always 0), bit 5 WRITE, bit 8 PHYS, bit 10 IO.
  - Memory cycles: [14:35] = address.
  - IO cycles: [14:17] = IODEV, [18:35] = cmdADDR[18:35].
  - All other bits 0.
  - PHYS = 1 for IO cycles, cmdPHYS otherwise.
- Reset values: all outputs 0, state IDLE, timeout counter 0, cmdRDDATA 0, cmdNXM 0.
- States: IDLE, REQ, DONE.
- IDLE:
  - cmdGO=1 latches cmdWR, cmdIO, cmdPHYS, cmdADDR and cmdDATA into internal registers.
  - Clears cmdNXM and counter; next state is REQ.
  - busREQO=0; busADDRO=0; busDATAO=0.
- REQ:
  - busREQO=1, busADDRO and busDATAO driven from the latched registers (write data is 0 on reads); counter increments each cycle.
  - busACKI=1: on a read, cmdRDDATA <= busDATAI; next state is DONE.
  - Else if counter == TIMEOUT-1: cmdNXM <= 1; next state is DONE.
  - If ACK and timeout occur in the same cycle, ACK wins and cmdNXM stays 0.
- DONE:
  - cmdDONE=1 for exactly one cycle; busREQO=0; busADDRO=0; next state is IDLE.
- Latency: cmdGO at edge N puts busREQO high for edge N+1. With busACKI present at the first REQ edge, cmdDONE is high in the cycle after that edge. Minimum command-to-command spacing is 3 cycles.
- cmdGO while not IDLE is ignored (no queueing). Command inputs may change freely after acceptance.
- busACKI outside REQ is ignored.
- Write cycles never update cmdRDDATA.
- Reset mid-cycle drops busREQO asynchronously and returns to IDLE; no cmdDONE is produced.

Optional Feature:
- Macro: KS10_MEMINIT_RETRY_EN.
- Defined:
  - On timeout, the block re-enters REQ once with the counter cleared, and busREQO is dropped for exactly one intervening cycle.
  - NXM is reported only if the retry also times out.
  - A 1-bit retry flag is cleared on cmdGO.
- Undefined: the first timeout reports NXM immediately, and no retry logic is synthesized.

Test Plan:
- Memory read: cmdGO, cmdWR=0, cmdIO=0, cmdPHYS=1, cmdADDR=22'o123456; responder acks on the 2nd REQ cycle with busDATAI=36'o123456765432 -> busADDRO has bits 3 and 8 set with addr 22'o123456, cmdRDDATA=36'o123456765432, one cmdDONE pulse, cmdNXM=0.
- Memory write: cmdWR=1, cmdDATA=36'o777000111222, immediate ack -> busADDRO bit 5 set, busDATAO=36'o777000111222 during REQ, cmdRDDATA unchanged, cmdDONE 2 cycles after cmdGO.
- IO read, IODEV=0, cmdADDR[18:35]=18'o100000 -> bits 3, 8 and 10 set, [14:17]=0, [18:35]=18'o100000; read data captured.
- Timeout, no ack, TIMEOUT=64 -> busREQO high exactly 64 cycles, then cmdNXM=1 with cmdDONE; next cmdGO clears cmdNXM. With RETRY_EN: 64 + 1 + 64 cycles before NXM; ack during the retry gives cmdNXM=0.
- Boundaries: ack exactly on the 64th REQ cycle -> cmdNXM=0. cmdGO pulsed while busy -> ignored, one cmdDONE only.
- Reset: assert rst during REQ -> busREQO=0 immediately, no cmdDONE, all outputs 0; a new cmdGO after release works normally.
